// File: rtl/trim_dac_loader_if.sv
// trim_dac_loader_if
//   Write/commit request bus feeding trim_dac_loader.
//   wr_valid  : trim write request (source holds until wr_ready)
//   wr_ready  : loader can accept a write or commit this cycle
//   wr_ch     : channel index; values >= NUM_CH are rejected
//   wr_code   : 12-bit DAC code for wr_ch
//   wr_commit : request a DAC update, with a write or on its own
//   master = request source, slave = trim_dac_loader.
interface trim_dac_loader_if;
  logic        wr_valid;
  logic        wr_ready;
  logic [3:0]  wr_ch;
  logic [11:0] wr_code;
  logic        wr_commit;

  modport master (
    output wr_valid, wr_ch, wr_code, wr_commit,
    input  wr_ready
  );

  modport slave (
    input  wr_valid, wr_ch, wr_code, wr_commit,
    output wr_ready
  );
endinterface

// File: rtl/trim_dac_loader.sv
// trim_dac_loader
//   Upstream front end for trim_dac_ctrl. Takes per-channel 12-bit trim codes,
//   writes them into the trim LUT as two 7-bit halves, and on commit fires a
//   single-cycle load_dacs strobe followed by a LUT write lockout that covers
//   the whole DAC shift-out.
//
// Ports
//   clk40, rst : 40 MHz clock, asynchronous active-high reset
//   wr         : write/commit request bus (slave side)
//   lut_in     : LUT write data (7 bits)
//   lut_addr   : LUT write address, 2*ch for the low half, 2*ch+1 for the high
//   lut_we     : LUT write enable
//   load_dacs  : one-cycle start strobe to trim_dac_ctrl
//   busy       : high from the load_dacs cycle until the lockout expires
//   err_pulse  : one-cycle pulse when an out-of-range channel write is accepted
//
// Optional build macro TRIM_SHADOW_RB_EN
//   Adds rb_ch (in, 4) and rb_code (out, 12): registered readback of a shadow
//   copy of the last code written per channel, 0 for rb_ch >= NUM_CH.
module trim_dac_loader #(
  parameter int unsigned BUSY_CYCLES = 640,
  parameter int unsigned NUM_CH      = 9
) (
  input  logic              clk40,
  input  logic              rst,
  trim_dac_loader_if.slave  wr,
  output logic [6:0]        lut_in,
  output logic [4:0]        lut_addr,
  output logic              lut_we,
  output logic              load_dacs,
  output logic              busy,
  output logic              err_pulse
`ifdef TRIM_SHADOW_RB_EN
  ,
  input  logic [3:0]        rb_ch,
  output logic [11:0]       rb_code
`endif
);

  localparam int unsigned       CW       = $clog2(BUSY_CYCLES + 1);
  localparam logic [CW-1:0]     CNT_LOAD = CW'(BUSY_CYCLES - 1);
  localparam logic [4:0]        NUM_CH_W = 5'(NUM_CH);

  typedef enum logic [2:0] {IDLE, WR_LO, WR_HI, TRIG, BUSY} state_t;

  state_t        state;
  logic [3:0]    ch_q;
  logic [11:0]   code_q;
  logic          commit_q;
  logic [CW-1:0] cnt;
  logic          pending;
  logic          ch_ok;

  assign ch_ok       = ({1'b0, wr.wr_ch} < NUM_CH_W);
  assign wr.wr_ready = (state == IDLE) & ~rst;

  always_ff @(posedge clk40 or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ch_q      <= '0;
      code_q    <= '0;
      commit_q  <= 1'b0;
      cnt       <= '0;
      pending   <= 1'b0;
      lut_in    <= '0;
      lut_addr  <= '0;
      lut_we    <= 1'b0;
      load_dacs <= 1'b0;
      busy      <= 1'b0;
      err_pulse <= 1'b0;
    end else begin
      lut_we    <= 1'b0;
      load_dacs <= 1'b0;
      err_pulse <= 1'b0;
      unique case (state)
        IDLE: begin
          if (wr.wr_valid && ch_ok) begin
            ch_q     <= wr.wr_ch;
            code_q   <= wr.wr_code;
            commit_q <= wr.wr_commit;
            lut_we   <= 1'b1;
            lut_addr <= {wr.wr_ch, 1'b0};
            lut_in   <= wr.wr_code[6:0];
            state    <= WR_LO;
          end else if (wr.wr_valid || wr.wr_commit) begin
            err_pulse <= wr.wr_valid;
            if (wr.wr_commit) begin
              load_dacs <= 1'b1;
              busy      <= 1'b1;
              pending   <= 1'b0;
              state     <= TRIG;
            end
          end
        end
        WR_LO: begin
          lut_we   <= 1'b1;
          lut_addr <= {ch_q, 1'b1};
          lut_in   <= {2'b00, code_q[11:7]};
          state    <= WR_HI;
        end
        WR_HI: begin
          if (commit_q) begin
            load_dacs <= 1'b1;
            busy      <= 1'b1;
            pending   <= 1'b0;
            state     <= TRIG;
          end else begin
            state <= IDLE;
          end
        end
        TRIG: begin
          cnt   <= CNT_LOAD;
          state <= BUSY;
          if (wr.wr_commit) pending <= 1'b1;
        end
        BUSY: begin
          if (cnt == '0) begin
            // A commit landing on the final lockout cycle is treated as pending
            // so it is not silently dropped on the way back to IDLE.
            if (pending || wr.wr_commit) begin
              load_dacs <= 1'b1;
              pending   <= 1'b0;
              state     <= TRIG;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end else begin
            cnt <= cnt - 1'b1;
            if (wr.wr_commit) pending <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef TRIM_SHADOW_RB_EN
  logic [11:0] shadow [NUM_CH];

  always_ff @(posedge clk40 or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_CH; i++) shadow[i] <= '0;
      rb_code <= '0;
    end else begin
      if (state == WR_HI) shadow[ch_q] <= code_q;
      rb_code <= ({1'b0, rb_ch} < NUM_CH_W) ? shadow[rb_ch] : '0;
    end
  end
`endif

endmodule

// File: doc/trim_dac_loader.md
Name: trim_dac_loader

Overview:
- Upstream front end for trim_dac_ctrl.
- Accepts 12-bit trim codes per channel (index 0-8) on a valid/ready interface.
- Splits each code into the two 7-bit LUT halves and drives the trim LUT write port (lut_in/lut_addr/lut_we).
- On commit, issues the single-cycle load_dacs strobe, then locks out LUT writes for the full DAC shift-out period so the LUT is never modified while it is being read.

Parameters:
- BUSY_CYCLES, 640, clk40 cycles of write lockout after load_dacs (covers the 300 clk20 state sequence plus margin).
- NUM_CH, 9, number of valid trim channels; index >= NUM_CH is rejected.

Ports:
- clk40  in  1  40 MHz system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_valid  in  1  trim write request.
- wr_ready  out  1  high when a write or commit can be accepted.
- wr_ch  in  4  channel index 0..8.
- wr_code  in  12  DAC code for wr_ch.
- wr_commit  in  1  sampled with wr_valid, or alone in IDLE; requests a DAC update.
- lut_in  out  7  LUT write data, to trim_dac_ctrl lut_in.
- lut_addr  out  5  LUT write address, to trim_dac_ctrl lut_addr.
- lut_we  out  1  LUT write enable, to trim_dac_ctrl lut_we.
- load_dacs  out  1  one-cycle start strobe, to trim_dac_ctrl load_dacs.
- busy  out  1  high from the load_dacs cycle until the lockout expires.
- err_pulse  out  1  one-cycle pulse when a write with wr_ch >= NUM_CH is accepted.

Behaviour:
- Reset (asynchronous): state=IDLE.
  - lut_in=0, lut_addr=0, lut_we=0, load_dacs=0, busy=0, err_pulse=0.
  - Lockout counter=0, pending flag=0.
  - wr_ready=0 while rst is high.
- Outputs are registered, except wr_ready = (state==IDLE) & ~rst.
- States: IDLE, WR_LO, WR_HI, TRIG, BUSY.
- IDLE:
  - wr_valid & wr_ready & wr_ch < NUM_CH: capture ch/code/commit, go to WR_LO.
  - wr_valid & wr_ch >= NUM_CH: accept, err_pulse=1 next cycle, no LUT write. If wr_commit is also set, go to TRIG; otherwise stay in IDLE.
  - wr_commit without wr_valid: go to TRIG.
- WR_LO (1 cycle): lut_we=1, lut_addr=2*ch, lut_in=code[6:0].
- WR_HI (1 cycle): lut_we=1, lut_addr=2*ch+1, lut_in={2'b00, code[11:7]}. Next state is TRIG if the captured commit was set, else IDLE.
- Write latency: accept edge N; low half written during cycle N+1; high half during N+2; wr_ready high again in N+3 (when there is no commit).
- TRIG (1 cycle): load_dacs=1, busy=1, counter loaded with BUSY_CYCLES-1, go to BUSY.
- BUSY:
  - busy=1 and wr_ready=0; counter decrements each cycle.
  - Counter==0: go to IDLE, or to TRIG if pending.
  - Total busy high time = BUSY_CYCLES+1 cycles per trigger.
- Pending flag:
  - wr_commit asserted during TRIG/BUSY sets pending; at most one is queued and further requests merge into it.
  - Pending clears when the next TRIG is entered.
  - wr_valid is ignored outside IDLE; the source must hold it until wr_ready.
- Simultaneous write + commit: both LUT halves are written before load_dacs, so the DAC update always includes the new code.
- Commit with no prior writes: load_dacs is still issued, reloading existing LUT contents.
- Reset mid-write (e.g. between WR_LO and WR_HI): the LUT keeps a half-updated entry; software must rewrite the channel after reset. No load_dacs is issued.
- Reset mid-BUSY: lockout aborted and pending cleared; wr_ready=1 on the first edge after reset release.

Optional Feature:
- Macro TRIM_SHADOW_RB_EN.
- When defined:
  - Adds inputs rb_ch[3:0] and output rb_code[11:0].
  - A 9x12 shadow register array is updated on the WR_HI cycle with the captured code.
  - rb_code is the registered shadow[rb_ch], one-cycle latency; it returns 0 for rb_ch >= NUM_CH.
  - The shadow array resets to 0.
- When undefined: no shadow storage and no readback ports.

Test Plan:
- Write ch=3, code=12'hABC, no commit -> cycle N+1: we=1 addr=6 din=7'h3C; N+2: we=1 addr=7 din=7'h15; load_dacs stays 0; wr_ready returns at N+3.
- Write ch=8, code=12'hFFF with commit -> addr 16/17 written (7'h7F, 7'h1F); then load_dacs high exactly 1 cycle; busy high 641 cycles; wr_ready low throughout.
- Commit during BUSY at count 100 -> second load_dacs issued 1 cycle after the first lockout ends; two commits during one BUSY -> only one extra trigger.
- Write ch=9 (and ch=15) -> err_pulse 1 cycle, lut_we never asserted, wr_ready back next cycle.
- Assert rst asynchronously mid-BUSY and between WR_LO/WR_HI -> all outputs 0 immediately without a clock edge; no load_dacs afterwards; wr_ready=1 after release.
- With TRIM_SHADOW_RB_EN: write ch=2 code=12'h5A5, rb_ch=2 -> rb_code=12'h5A5 one cycle after WR_HI; rb_ch=9 -> 0.
